// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for burst_word_memory
package mem_pkg;

    localparam logic [1:0]  ACC_1W     = 2'b00;
    localparam logic [1:0]  ACC_4W     = 2'b01;
    localparam logic [1:0]  ACC_8W     = 2'b10;
    localparam logic [1:0]  ACC_16W    = 2'b11;

    localparam logic        RW_WRITE   = 1'b0;
    localparam logic        RW_READ    = 1'b1;

    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

    function automatic logic [4:0] beats(input logic [1:0] access_size);
        case (access_size)
            ACC_1W:  beats = 5'd1;
            ACC_4W:  beats = 5'd4;
            ACC_8W:  beats = 5'd8;
            default: beats = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - IDLE/BURST sequencer producing one beat address per clock
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-3:0] i_word_addr,
    input  logic          i_rw,
    input  logic          i_enable,
    input  logic [1:0]    i_access_size,
    output logic          o_beat_valid,
    output logic          o_beat_start,
    output logic [AW-1:0] o_beat_addr,
    output logic          o_beat_rw,
    output logic          o_busy
);

    burst_state_t  r_state;
    logic [AW-1:0] r_base;
    logic          r_rw;
    logic [3:0]    r_beat;
    logic [3:0]    r_last;
    logic          r_busy;
    logic          w_idle;

    // Beat 0 runs straight from the inputs so a burst never costs a setup cycle.
    assign w_idle       = (r_state == ST_IDLE);
    assign o_beat_start = w_idle & i_enable;
    assign o_beat_valid = ~w_idle | i_enable;
    assign o_beat_addr  = w_idle ? {i_word_addr, 2'b00}
                                 : r_base + AW'({r_beat, 2'b00});
    assign o_beat_rw    = w_idle ? i_rw : r_rw;
    assign o_busy       = r_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_rw    <= RW_WRITE;
            r_beat  <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && i_access_size != ACC_1W) begin
                        r_state <= ST_BURST;
                        r_base  <= {i_word_addr, 2'b00};
                        r_rw    <= i_rw;
                        r_beat  <= 4'd1;
                        r_last  <= 4'(beats(i_access_size) - 5'd1);
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    if (r_beat == r_last) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_beat  <= r_beat + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/burst_word_memory.sv
// rtl/burst_word_memory.sv - big-endian byte-array word memory with 1/4/8/16-beat bursts
// Optional MEM_RANGE_CHECK_EN adds an err output flagging out-of-range or misaligned beats.
module burst_word_memory
    import mem_pkg::*;
#(
    parameter int          data_width    = 32,
    parameter int          address_width = 32,
    parameter int          depth         = 1048576,
    parameter logic [31:0] start_addr    = START_ADDR
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                     err
`endif
);

    localparam int IW = $clog2(depth);

    logic [7:0]               r_mem [0:depth-1];
    logic                     w_beat_valid;
    logic                     w_beat_start;
    logic [address_width-1:0] w_beat_addr;
    logic                     w_beat_rw;
    logic [address_width-1:0] w_offset;
    logic                     w_in_range;
    logic [IW-1:0]            w_idx;
    logic                     w_unused_addr_lo;

    mem_burst_ctrl #(.AW(address_width)) u_ctrl (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_word_addr   (address[address_width-1:2]),
        .i_rw          (rw),
        .i_enable      (enable),
        .i_access_size (access_size),
        .o_beat_valid  (w_beat_valid),
        .o_beat_start  (w_beat_start),
        .o_beat_addr   (w_beat_addr),
        .o_beat_rw     (w_beat_rw),
        .o_busy        (busy)
    );

    // Extra bit keeps offset+3 from wrapping past the top of the address space.
    assign w_offset         = w_beat_addr - address_width'(start_addr);
    assign w_in_range       = ({1'b0, w_offset} + (address_width+1)'(3)) < (address_width+1)'(depth);
    assign w_idx            = w_offset[IW-1:0];
    assign w_unused_addr_lo = ^{address[1:0], w_beat_start};

    always_ff @(posedge clock) begin
        if (w_beat_valid && w_beat_rw == RW_WRITE && w_in_range) begin
            r_mem[w_idx]           <= data_in[31:24];
            r_mem[w_idx + IW'(1)]  <= data_in[23:16];
            r_mem[w_idx + IW'(2)]  <= data_in[15:8];
            r_mem[w_idx + IW'(3)]  <= data_in[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (w_beat_valid && w_beat_rw == RW_READ) begin
            data_out <= w_in_range ? {r_mem[w_idx], r_mem[w_idx + IW'(1)],
                                      r_mem[w_idx + IW'(2)], r_mem[w_idx + IW'(3)]}
                                   : '0;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= w_beat_valid && (!w_in_range || (w_beat_start && address[1:0] != 2'b00));
        end
    end
`endif

endmodule

// File: tb/tb_burst_word_memory.sv
// tb/tb_burst_word_memory.sv - directed self-checking bench for burst_word_memory
module tb_burst_word_memory;

    logic        clock;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;
`ifdef MEM_RANGE_CHECK_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    burst_word_memory dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .err         (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        enable      = en;
        rw          = r;
        access_size = sz;
        address     = a;
        data_in     = d;
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_data_out", data_out, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // single write then read
        drive(1'b1, 1'b0, 2'b00, 32'h8002_0000, 32'h27BD_FFF8);
        tick();
        check("single_wr_busy", {31'b0, busy}, 32'h0);
        drive(1'b1, 1'b1, 2'b00, 32'h8002_0000, 32'h0);
        tick();
        check("single_rd_data", data_out, 32'h27BD_FFF8);
        check("single_rd_busy", {31'b0, busy}, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        check("idle_hold", data_out, 32'h27BD_FFF8);

        // 4-word write burst; enable dropped after beat 0 is ignored
        drive(1'b1, 1'b0, 2'b01, 32'h8002_0000, 32'h1111_1111);
        tick();
        check("wr4_busy_b0", {31'b0, busy}, 32'h1);
        drive(1'b0, 1'b1, 2'b00, 32'h8002_0800, 32'h2222_2222);
        tick();
        check("wr4_busy_b1", {31'b0, busy}, 32'h1);
        data_in = 32'h3333_3333;
        tick();
        check("wr4_busy_b2", {31'b0, busy}, 32'h1);
        data_in = 32'h4444_4444;
        tick();
        check("wr4_busy_b3", {31'b0, busy}, 32'h0);

        // 4-word read burst
        drive(1'b1, 1'b1, 2'b01, 32'h8002_0000, 32'h0);
        tick();
        check("rd4_b0", data_out, 32'h1111_1111);
        check("rd4_busy_b0", {31'b0, busy}, 32'h1);
        enable = 1'b0;
        tick();
        check("rd4_b1", data_out, 32'h2222_2222);
        tick();
        check("rd4_b2", data_out, 32'h3333_3333);
        tick();
        check("rd4_b3", data_out, 32'h4444_4444);
        check("rd4_busy_end", {31'b0, busy}, 32'h0);

        // endianness and ignored low address bits
        drive(1'b1, 1'b0, 2'b00, 32'h8002_0004, 32'hAABB_CCDD);
        tick();
        check("endian_byte4", {24'b0, dut.r_mem[4]}, 32'h0000_00AA);
        check("endian_byte7", {24'b0, dut.r_mem[7]}, 32'h0000_00DD);
        drive(1'b1, 1'b1, 2'b00, 32'h8002_0006, 32'h0);
        tick();
        check("endian_rd_unaligned", data_out, 32'hAABB_CCDD);

        // range boundary
        drive(1'b1, 1'b0, 2'b00, 32'h8011_FFFC, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b1, 2'b00, 32'h8011_FFFC, 32'h0);
        tick();
        check("last_word_rd", data_out, 32'h1234_5678);
        drive(1'b1, 1'b0, 2'b00, 32'h8012_0000, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b1, 2'b00, 32'h8012_0000, 32'h0);
        tick();
        check("oor_rd_zero", data_out, 32'h0);
        drive(1'b1, 1'b1, 2'b00, 32'h8002_0000, 32'h0);
        tick();
        check("oor_wr_dropped", data_out, 32'h1111_1111);
        drive(1'b1, 1'b1, 2'b01, 32'h8011_FFFC, 32'h0);
        tick();
        check("edge_rd4_b0", data_out, 32'h1234_5678);
        enable = 1'b0;
        tick();
        check("edge_rd4_b1", data_out, 32'h0);
        tick();
        check("edge_rd4_b2", data_out, 32'h0);
        tick();
        check("edge_rd4_b3", data_out, 32'h0);

        // 8-word write, then 8-word read chained into a single write
        drive(1'b1, 1'b0, 2'b10, 32'h8002_0040, 32'hA000_0000);
        tick();
        enable = 1'b0;
        for (int k = 1; k < 8; k++) begin
            data_in = 32'hA000_0000 + k;
            tick();
        end
        check("wr8_busy_end", {31'b0, busy}, 32'h0);
        drive(1'b1, 1'b1, 2'b10, 32'h8002_0040, 32'h0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("rd8_b%0d", k), data_out, 32'hA000_0000 + k);
        end
        drive(1'b1, 1'b0, 2'b00, 32'h8002_0100, 32'hCAFE_F00D);
        tick();
        check("rd8_b7", data_out, 32'hA000_0007);
        check("rd8_busy_end", {31'b0, busy}, 32'h0);
        tick();
        enable = 1'b0;
        check("b2b_wr_busy", {31'b0, busy}, 32'h0);
        check("b2b_hold", data_out, 32'hA000_0007);
        drive(1'b1, 1'b1, 2'b00, 32'h8002_0100, 32'h0);
        tick();
        check("b2b_wr_landed", data_out, 32'hCAFE_F00D);

        // reset in the middle of a read burst
        drive(1'b1, 1'b1, 2'b11, 32'h8002_0040, 32'h0);
        tick();
        enable = 1'b0;
        tick();
        check("preabort_busy", {31'b0, busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_data_out", data_out, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_abort_busy", {31'b0, busy}, 32'h0);
        drive(1'b1, 1'b1, 2'b00, 32'h8002_0044, 32'h0);
        tick();
        check("post_abort_rd", data_out, 32'hA000_0001);
        enable = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
